// File: rtl/dlx_mmio_bridge.sv
// dlx_mmio_bridge: data-side bridge between the DLX d_* port and the board.
// Each CPU access goes either to the data RAM or to a memory-mapped I/O page.
// The I/O page holds HEX digits, LEDR, SW, KEY, a cycle counter and an error flag.
// Reads use a ready/valid handshake, so RAM latency is free and MMIO reads take one cycle.
module dlx_mmio_bridge #(
    parameter int unsigned RAM_ADDR_WIDTH = 10,
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
    parameter int unsigned N_HEX          = 6,
    parameter int unsigned LED_WIDTH      = 10,
    parameter int unsigned SW_WIDTH       = 10,
    parameter int unsigned KEY_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               d_address,
    input  logic                      d_read_enable,
    input  logic                      d_write_enable,
    input  logic [31:0]               d_data_write,
    output logic                      d_ready,
    output logic [31:0]               d_data_read,
    output logic                      d_data_valid,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_we,
    output logic [31:0]               ram_wdata,
    input  logic [31:0]               ram_rdata,
    input  logic                      ram_rdata_valid,
    input  logic [SW_WIDTH-1:0]       sw,
    input  logic [KEY_WIDTH-1:0]      key,
    output logic [LED_WIDTH-1:0]      ledr,
    output logic [7*N_HEX-1:0]        hex
);

    localparam int unsigned HEX_VAL_W = 4 * N_HEX;

    // Word offsets inside the MMIO page (byte offset / 4).
    localparam logic [13:0] REG_HEX_VAL = 14'd0;
    localparam logic [13:0] REG_HEX_EN  = 14'd1;
    localparam logic [13:0] REG_LEDR    = 14'd2;
    localparam logic [13:0] REG_SW      = 14'd3;
    localparam logic [13:0] REG_KEY     = 14'd4;
    localparam logic [13:0] REG_CYCLES  = 14'd5;
    localparam logic [13:0] REG_ERR     = 14'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_RAM  = 2'd1,
        ST_RD_MMIO = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [HEX_VAL_W-1:0]   hex_val_q, hex_val_d;
    logic [N_HEX-1:0]       hex_en_q, hex_en_d;
    logic [7*N_HEX-1:0]     hex_q, hex_d;
    logic [LED_WIDTH-1:0]   ledr_q, ledr_d;
    logic [31:0]            cycles_q, cycles_d;
    logic                   err_q, err_d;
    logic [31:0]            mmio_rdata_q, mmio_rdata_d;
    logic [SW_WIDTH-1:0]    sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [KEY_WIDTH-1:0]   key_meta_q, key_meta_d, key_sync_q, key_sync_d;

    logic                   mmio_hit;
    logic [13:0]            reg_word;
    logic                   req_accept;
    logic                   wr_accept;
    logic                   rd_accept;
    logic [31:0]            reg_rdata;
    logic                   reg_known;
    logic                   addr_lsb_unused;

    // Standard active-low 7-segment pattern, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Address decode and handshake acceptance. Reset blocks any request in its cycle.
    assign mmio_hit        = (d_address[31:16] == MMIO_BASE[31:16]);
    assign reg_word        = d_address[15:2];
    assign addr_lsb_unused = ^d_address[1:0];
    assign d_ready         = (state_q == ST_IDLE);
    assign req_accept      = (d_read_enable | d_write_enable) & d_ready & ~reset;
    assign wr_accept       = req_accept & d_write_enable;
    // A read issued together with a write is dropped: the write wins.
    assign rd_accept       = req_accept & ~d_write_enable;

    // RAM address and write data pass straight through; only the write strobe is decoded.
    assign ram_addr  = d_address[RAM_ADDR_WIDTH+1:2];
    assign ram_wdata = d_data_write;
    assign ram_we    = wr_accept & ~mmio_hit;

    assign ledr = ledr_q;
    assign hex  = hex_q;

    // MMIO read multiplexer: narrow registers are zero-extended to 32 bits.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        reg_rdata = '0;
        reg_known = 1'b1;
        case (reg_word)
            REG_HEX_VAL: reg_rdata[HEX_VAL_W-1:0] = hex_val_q;
            REG_HEX_EN:  reg_rdata[N_HEX-1:0]     = hex_en_q;
            REG_LEDR:    reg_rdata[LED_WIDTH-1:0] = ledr_q;
            REG_SW:      reg_rdata[SW_WIDTH-1:0]  = sw_sync_q;
            REG_KEY:     reg_rdata[KEY_WIDTH-1:0] = key_sync_q;
            REG_CYCLES:  reg_rdata                = cycles_q;
            REG_ERR:     reg_rdata[0]             = err_q;
            default:     reg_known                = 1'b0;
        endcase
    end

    // Next-state for the MMIO registers, counter, error flag, synchronisers and digit outputs.
    always_comb begin
        hex_val_d    = hex_val_q;
        hex_en_d     = hex_en_q;
        ledr_d       = ledr_q;
        cycles_d     = cycles_q + 32'd1;
        err_d        = err_q;
        mmio_rdata_d = mmio_rdata_q;
        sw_meta_d    = sw;
        sw_sync_d    = sw_meta_q;
        key_meta_d   = ~key;
        key_sync_d   = key_meta_q;

        if (wr_accept && mmio_hit) begin
            case (reg_word)
                REG_HEX_VAL: hex_val_d = d_data_write[HEX_VAL_W-1:0];
                REG_HEX_EN:  hex_en_d  = d_data_write[N_HEX-1:0];
                REG_LEDR:    ledr_d    = d_data_write[LED_WIDTH-1:0];
                REG_SW, REG_KEY: begin
                end
                REG_CYCLES:  cycles_d  = d_data_write;
                REG_ERR:     if (d_data_write[0]) err_d = 1'b0;
                default:     err_d     = 1'b1;
            endcase
        end

        // Read data is captured at acceptance and presented on the following cycle.
        if (rd_accept && mmio_hit) begin
            mmio_rdata_d = reg_rdata;
            if (!reg_known) err_d = 1'b1;
        end

        hex_d = '1;
        for (int i = 0; i < int'(N_HEX); i++) begin
            hex_d[7*i +: 7] = hex_en_q[i] ? seg7(hex_val_q[4*i +: 4]) : 7'h7F;
        end
    end

    // Read FSM: tracks the single outstanding read and produces the completion pulse.
    always_comb begin
        state_d      = state_q;
        d_data_valid = 1'b0;
        d_data_read  = '0;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept) state_d = mmio_hit ? ST_RD_MMIO : ST_RD_RAM;
            end
            ST_RD_RAM: begin
                if (ram_rdata_valid) begin
                    state_d = ST_IDLE;
                    // A read being cancelled by reset must not report completion.
                    if (!reset) begin
                        d_data_valid = 1'b1;
                        d_data_read  = ram_rdata;
                    end
                end
            end
            ST_RD_MMIO: begin
                state_d = ST_IDLE;
                if (!reset) begin
                    d_data_valid = 1'b1;
                    d_data_read  = mmio_rdata_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset; reset clears every flop including the synchronisers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (reset) begin
            state_q      <= ST_IDLE;
            hex_val_q    <= '0;
            hex_en_q     <= '0;
            hex_q        <= '1;
            ledr_q       <= '0;
            cycles_q     <= '0;
            err_q        <= 1'b0;
            mmio_rdata_q <= '0;
            sw_meta_q    <= '0;
            sw_sync_q    <= '0;
            key_meta_q   <= '0;
            key_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            hex_val_q    <= hex_val_d;
            hex_en_q     <= hex_en_d;
            hex_q        <= hex_d;
            ledr_q       <= ledr_d;
            cycles_q     <= cycles_d;
            err_q        <= err_d;
            mmio_rdata_q <= mmio_rdata_d;
            sw_meta_q    <= sw_meta_d;
            sw_sync_q    <= sw_sync_d;
            key_meta_q   <= key_meta_d;
            key_sync_q   <= key_sync_d;
        end
    end

endmodule
